tremolo_mc: RTL

Multichannel successor to the single-channel tremolo: amplitude-modulates `CH` audio channels from one shared LFO. The LFO has a selectable waveform, a directly programmed phase increment, and an optional per-channel phase spread for stereo/auto-pan. Channels are processed time-multiplexed through one multiplier, and all outputs are presented coherently with a single `valid_o` pulse. It sits in the effects chain between the input conditioner and the output mixer, clocked at system clock and gated by `sample_tick_i`.

---
 rtl/tremolo_mc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tremolo_mc.sv
// Multichannel tremolo: one shared LFO amplitude-modulates CH lanes through a single
// time-multiplexed DW x 9 multiplier, presenting all lanes together with one valid pulse.
module tremolo_mc #(
  parameter int unsigned DW      = 24,
  parameter int unsigned CH      = 2,
  parameter int unsigned PHASE_W = 24
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  sample_tick_i,
  input  logic [CH*DW-1:0]      data_i,
  input  logic [PHASE_W-1:0]    phase_inc_i,
  input  logic [1:0]            wave_i,
  input  logic [7:0]            level_i,
  input  logic                  spread_i,
  input  logic                  enable_i,
  output logic [CH*DW-1:0]      data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int unsigned LW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CW = $clog2(CH) + 1;
  localparam int unsigned SH = PHASE_W - $clog2(CH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       ch_cnt_q;
  logic [PHASE_W-1:0]  acc_q, acc_snap_q;
  logic [DW-1:0]       snap_q [CH];
  logic [DW-1:0]       shadow_q [CH];
  logic [1:0]          wave_q;
  logic [7:0]          level_q;
  logic                spread_q, enable_q;
  logic [8:0]          g_q, g_d;
  logic                s1_vld_q;
  logic [LW-1:0]       s1_lane_q;
  logic [CH*DW-1:0]    data_q, shadow_flat;
  logic                valid_q, ovr_q;

  logic                tick_accept, s0_act, s1_last;
  logic [LW-1:0]       lane0;
  logic [PHASE_W-1:0]  lane_off, p;
  logic [7:0]          u, m;
  logic [15:0]         lm;
  logic signed [DW-1:0] x, y;
  logic signed [DW+8:0] prod;

  assign busy_o      = (state_q != StIdle);
  assign tick_accept = sample_tick_i && (state_q == StIdle);
  assign s0_act      = (state_q == StRun) && (ch_cnt_q < CW'(CH));
  assign lane0       = ch_cnt_q[LW-1:0];

  // Stage 0: per-lane LFO phase, waveform and gain.
  always_comb begin
    lane_off = spread_q ? (PHASE_W'(lane0) << SH) : '0;
    p        = acc_snap_q + lane_off;
    u        = p[PHASE_W-1 -: 8];
    m        = 8'd0;
    case (wave_q)
      2'd0:    m = u[7] ? ~{u[6:0], 1'b0} : {u[6:0], 1'b0};
      2'd1:    m = u[7] ? 8'd0 : 8'd255;
      2'd2:    m = 8'd255 - u;
      default: m = u;
    endcase
    lm  = 16'(level_q) * 16'(m);
    g_d = 9'd256 - {1'b0, lm[15:8]};
  end

  // Stage 1: the only wide multiplier, shared across lanes.
  always_comb begin
    x       = snap_q[s1_lane_q];
    prod    = x * $signed({1'b0, g_q});
    y       = enable_q ? prod[DW+7:8] : x;
    s1_last = s1_vld_q && (s1_lane_q == LW'(CH - 1));
  end

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < int'(CH); k++) begin
      shadow_flat[k*DW +: DW] = shadow_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (sample_tick_i) state_d = StRun;
      StRun:   if (s1_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= StIdle;
      ch_cnt_q   <= '0;
      acc_q      <= '0;
      acc_snap_q <= '0;
      wave_q     <= '0;
      level_q    <= '0;
      spread_q   <= 1'b0;
      enable_q   <= 1'b0;
      g_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_lane_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      for (int k = 0; k < int'(CH); k++) begin
        snap_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= (state_q == StDone);
      ovr_q    <= sample_tick_i && busy_o;
      s1_vld_q <= s0_act;
      if (sample_tick_i) acc_q <= acc_q + phase_inc_i;
      if (tick_accept) begin
        ch_cnt_q   <= '0;
        acc_snap_q <= acc_q;
        wave_q     <= wave_i;
        level_q    <= level_i;
        spread_q   <= spread_i;
        enable_q   <= enable_i;
        for (int k = 0; k < int'(CH); k++) begin
          snap_q[k] <= data_i[k*DW +: DW];
        end
      end
      if (s0_act) begin
        ch_cnt_q  <= ch_cnt_q + 1'b1;
        g_q       <= g_d;
        s1_lane_q <= lane0;
      end
      if (s1_vld_q) shadow_q[s1_lane_q] <= y;
      if (state_q == StDone) data_q <= shadow_flat;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule
